// File: rtl/blackparrot_fpga_host_io_in.sv
// Host-to-BlackParrot MMIO initiator: turns 32b host command words into single-beat
// AXI4 reads/writes on the BP I/O-in port and returns read data through a response FIFO.
module blackparrot_fpga_host_io_in #(
  parameter int unsigned M_AXI_ADDR_WIDTH  = 64,
  parameter int unsigned M_AXI_DATA_WIDTH  = 64,
  parameter int unsigned fifo_data_width_p = 32,
  parameter int unsigned RESP_ELS          = 16
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic                            cmd_v_i,
  input  logic [fifo_data_width_p-1:0]    cmd_data_i,
  output logic                            cmd_ready_and_o,

  output logic                            resp_v_o,
  output logic [fifo_data_width_p-1:0]    resp_data_o,
  input  logic                            resp_yumi_i,
  output logic [31:0]                     resp_count_o,

  output logic                            error_o,

  output logic [M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                      m_axi_awsize,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic [1:0]                      m_axi_bresp,
  output logic [M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                      m_axi_arsize,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  input  logic [1:0]                      m_axi_rresp
);

  localparam int unsigned PTR_W = $clog2(RESP_ELS);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    e_hdr, e_addr, e_data, e_aw_w, e_b, e_ar, e_r, e_ill_r
  } state_e;

  state_e state_r, state_n;

  logic        op_r, illegal_r, error_r, aw_done_r, w_done_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, data_r;

  logic        hdr_we, addr_we, data_we, err_set, push, pop, space, illegal_c;
  logic [31:0] push_data, rd_field;
  logic [2:0]  align_mask;
  logic [7:0]  strb_base;
  logic [M_AXI_DATA_WIDTH-1:0] rd_shifted;

  logic [fifo_data_width_p-1:0] mem [RESP_ELS];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Alignment check against the latched size and the incoming address word
  always_comb begin
    align_mask = 3'b000;
    case (size_r)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      default: align_mask = 3'b011;
    endcase
    illegal_c = (size_r == 2'd3) || ((cmd_data_i[2:0] & align_mask) != 3'b000);
  end

  // Read lane extraction, masked to the access size
  always_comb begin
    rd_shifted = m_axi_rdata >> {addr_r[2:0], 3'b000};
    rd_field   = 32'h0;
    case (size_r)
      2'd0:    rd_field = 32'(rd_shifted[7:0]);
      2'd1:    rd_field = 32'(rd_shifted[15:0]);
      default: rd_field = rd_shifted[31:0];
    endcase
  end

  assign space = (count_r != CNT_W'(RESP_ELS));
  assign pop   = resp_yumi_i && resp_v_o;

  always_ff @(posedge clk) begin
    if (reset) state_r <= e_hdr;
    else       state_r <= state_n;
  end

  always_comb begin
    state_n         = state_r;
    cmd_ready_and_o = 1'b0;
    hdr_we          = 1'b0;
    addr_we         = 1'b0;
    data_we         = 1'b0;
    err_set         = 1'b0;
    push            = 1'b0;
    push_data       = 32'h0;
    case (state_r)
      e_hdr: begin
        cmd_ready_and_o = !reset;
        if (cmd_v_i && !reset) begin
          hdr_we  = 1'b1;
          state_n = e_addr;
        end
      end
      e_addr: begin
        cmd_ready_and_o = !reset;
        if (cmd_v_i && !reset) begin
          addr_we = 1'b1;
          err_set = illegal_c;
          if (op_r)           state_n = e_data;
          else if (illegal_c) state_n = e_ill_r;
          else                state_n = e_ar;
        end
      end
      e_data: begin
        cmd_ready_and_o = !reset;
        if (cmd_v_i && !reset) begin
          data_we = 1'b1;
          state_n = illegal_r ? e_hdr : e_aw_w;
        end
      end
      e_aw_w: begin
        if ((aw_done_r || m_axi_awready) && (w_done_r || m_axi_wready)) state_n = e_b;
      end
      e_b: begin
        if (m_axi_bvalid) begin
          err_set = (m_axi_bresp != 2'b00);
          state_n = e_hdr;
        end
      end
      e_ar: begin
        if (m_axi_arready) state_n = e_r;
      end
      e_r: begin
        if (m_axi_rvalid && space) begin
          push      = 1'b1;
          push_data = rd_field;
          err_set   = (m_axi_rresp != 2'b00);
          state_n   = e_hdr;
        end
      end
      e_ill_r: begin
        if (space) begin
          push    = 1'b1;
          state_n = e_hdr;
        end
      end
      default: state_n = e_hdr;
    endcase
  end

  // Command fields, handshake flags and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r      <= 1'b0;
      size_r    <= 2'd0;
      addr_r    <= 32'h0;
      data_r    <= 32'h0;
      illegal_r <= 1'b0;
      error_r   <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (hdr_we) begin
        op_r   <= cmd_data_i[0];
        size_r <= cmd_data_i[2:1];
      end
      if (addr_we) begin
        addr_r    <= cmd_data_i;
        illegal_r <= illegal_c;
      end
      if (data_we) data_r <= cmd_data_i;
      if (err_set) error_r <= 1'b1;
      aw_done_r <= (state_r == e_aw_w) && (state_n == e_aw_w) && (aw_done_r || m_axi_awready);
      w_done_r  <= (state_r == e_aw_w) && (state_n == e_aw_w) && (w_done_r || m_axi_wready);
    end
  end

  always_comb begin
    strb_base = 8'h0F;
    case (size_r)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      default: strb_base = 8'h0F;
    endcase
    m_axi_wdata = {2{data_r}};
    case (size_r)
      2'd0:    m_axi_wdata = {8{data_r[7:0]}};
      2'd1:    m_axi_wdata = {4{data_r[15:0]}};
      default: m_axi_wdata = {2{data_r}};
    endcase
  end

  assign m_axi_wstrb   = strb_base << addr_r[2:0];
  assign m_axi_awaddr  = M_AXI_ADDR_WIDTH'(addr_r);
  assign m_axi_araddr  = M_AXI_ADDR_WIDTH'(addr_r);
  assign m_axi_awsize  = {1'b0, size_r};
  assign m_axi_arsize  = {1'b0, size_r};
  assign m_axi_awvalid = (state_r == e_aw_w) && !aw_done_r;
  assign m_axi_wvalid  = (state_r == e_aw_w) && !w_done_r;
  assign m_axi_bready  = (state_r == e_b);
  assign m_axi_arvalid = (state_r == e_ar);
  assign m_axi_rready  = (state_r == e_r) && space;
  assign error_o       = error_r;

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_r] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= (wr_ptr_r == PTR_W'(RESP_ELS - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= (rd_ptr_r == PTR_W'(RESP_ELS - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign resp_v_o     = (count_r != '0);
  assign resp_data_o  = mem[rd_ptr_r];
  assign resp_count_o = 32'(count_r);

endmodule

// File: tb/tb_blackparrot_fpga_host_io_in.sv
// Directed bench for the host-to-BP MMIO initiator, acting as host and AXI slave.
module tb_blackparrot_fpga_host_io_in;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_v_i;
  logic [31:0] cmd_data_i;
  logic        cmd_ready_and_o;
  logic        resp_v_o;
  logic [31:0] resp_data_o;
  logic        resp_yumi_i;
  logic [31:0] resp_count_o;
  logic        error_o;
  logic [63:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  blackparrot_fpga_host_io_in dut (
    .clk(clk), .reset(reset),
    .cmd_v_i(cmd_v_i), .cmd_data_i(cmd_data_i), .cmd_ready_and_o(cmd_ready_and_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .resp_count_o(resp_count_o), .error_o(error_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rresp(m_axi_rresp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    cmd_v_i    = 1'b1;
    cmd_data_i = w;
    for (int n = 0; n < 100 && !cmd_ready_and_o; n++) step();
    chk("cmd_ready_wait", cmd_ready_and_o, 1);
    step();
    cmd_v_i = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] hdr, input logic [31:0] addr,
                         input logic [63:0] rdata, input logic [1:0] rresp);
    send_word(hdr);
    send_word(addr);
    for (int n = 0; n < 100 && !m_axi_arvalid; n++) step();
    chk("arvalid_wait", m_axi_arvalid, 1);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rdata   = rdata;
    m_axi_rresp   = rresp;
    m_axi_rvalid  = 1'b1;
    for (int n = 0; n < 100 && !m_axi_rready; n++) step();
    chk("rready_wait", m_axi_rready, 1);
    step();
    m_axi_rvalid = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; cmd_v_i = 1'b0; cmd_data_i = '0; resp_yumi_i = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    step(); step(); step();

    // Reset values
    chk("rst_cmd_ready", cmd_ready_and_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_count", resp_count_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_axi_handshakes", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    reset = 1'b0;
    step();
    chk("idle_cmd_ready", cmd_ready_and_o, 1);

    // 4B write at 0x100004
    send_word(32'h5); send_word(32'h0010_0004); send_word(32'hDEAD_BEEF);
    chk("wr_awvalid", m_axi_awvalid, 1);
    chk("wr_wvalid", m_axi_wvalid, 1);
    chk("wr_awaddr", m_axi_awaddr, 64'h10_0004);
    chk("wr_awsize", m_axi_awsize, 2);
    chk("wr_wdata", m_axi_wdata, 64'hDEADBEEF_DEADBEEF);
    chk("wr_wstrb", m_axi_wstrb, 8'hF0);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    chk("wr_valids_drop", {m_axi_awvalid, m_axi_wvalid}, 0);
    chk("wr_bready", m_axi_bready, 1);
    m_axi_bvalid = 1'b1;
    step();
    m_axi_bvalid = 1'b0;
    chk("wr_bready_off", m_axi_bready, 0);
    chk("wr_error", error_o, 0);
    chk("wr_no_resp", resp_v_o, 0);

    // 1B read at 0x200003
    send_word(32'h0); send_word(32'h0020_0003);
    chk("rd_arvalid", m_axi_arvalid, 1);
    chk("rd_araddr", m_axi_araddr, 64'h20_0003);
    chk("rd_arsize", m_axi_arsize, 0);
    chk("rd_count0", resp_count_o, 0);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    chk("rd_rready", m_axi_rready, 1);
    m_axi_rdata = 64'h1122334455667788; m_axi_rvalid = 1'b1;
    step();
    m_axi_rvalid = 1'b0;
    chk("rd_resp_v", resp_v_o, 1);
    chk("rd_resp_data", resp_data_o, 32'h55);
    chk("rd_count1", resp_count_o, 1);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
    chk("rd_pop_count", resp_count_o, 0);

    // AW/W skew: W completes first, AW held off 5 cycles
    send_word(32'h5); send_word(32'h0000_0008); send_word(32'h1234_5678);
    chk("skew_wstrb", m_axi_wstrb, 8'h0F);
    chk("skew_wdata", m_axi_wdata, 64'h12345678_12345678);
    m_axi_wready = 1'b1;
    step();
    m_axi_wready = 1'b0;
    chk("skew_wvalid_drop", m_axi_wvalid, 0);
    chk("skew_awvalid_hold", m_axi_awvalid, 1);
    step(); step(); step(); step();
    chk("skew_awvalid_still", m_axi_awvalid, 1);
    chk("skew_no_bready_yet", m_axi_bready, 0);
    m_axi_awready = 1'b1;
    step();
    m_axi_awready = 1'b0;
    chk("skew_awvalid_drop", m_axi_awvalid, 0);
    chk("skew_bready", m_axi_bready, 1);
    m_axi_bvalid = 1'b1;
    step();
    m_axi_bvalid = 1'b0;
    chk("skew_one_b", m_axi_bready, 0);
    chk("skew_idle", cmd_ready_and_o, 1);

    // Fill the response FIFO, then stall the 17th read
    for (int i = 0; i < 16; i++) do_read(32'h0, 32'h0000_0100, 64'(i + 1), 2'b00);
    chk("bp_count_full", resp_count_o, 16);
    send_word(32'h0); send_word(32'h0000_0100);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    m_axi_rdata = 64'hAB; m_axi_rvalid = 1'b1;
    step();
    chk("bp_rready_low", m_axi_rready, 0);
    step();
    chk("bp_rready_still_low", m_axi_rready, 0);
    chk("bp_count_hold", resp_count_o, 16);
    chk("bp_head", resp_data_o, 32'h1);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;
    chk("bp_count_pop", resp_count_o, 15);
    chk("bp_rready_space", m_axi_rready, 1);
    step();
    m_axi_rvalid = 1'b0;
    chk("bp_count_refill", resp_count_o, 16);
    chk("bp_done", cmd_ready_and_o, 1);
    for (int i = 0; i < 16; i++) begin
      chk("bp_drain", resp_data_o, (i < 15) ? 64'(i + 2) : 64'hAB);
      resp_yumi_i = 1'b1;
      step();
      resp_yumi_i = 1'b0;
    end
    chk("bp_empty", resp_count_o, 0);

    // Illegal read (size 3)
    send_word(32'h6); send_word(32'h0);
    chk("ill_rd_no_ar", m_axi_arvalid, 0);
    chk("ill_rd_error", error_o, 1);
    step();
    chk("ill_rd_resp_v", resp_v_o, 1);
    chk("ill_rd_data", resp_data_o, 0);
    chk("ill_rd_no_ar2", m_axi_arvalid, 0);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;

    // Misaligned 2B write: data consumed, nothing issued
    do_reset();
    chk("rst_error_clear", error_o, 0);
    send_word(32'h3); send_word(32'h1);
    chk("mis_error", error_o, 1);
    send_word(32'hCAFE);
    chk("mis_no_aw_w", {m_axi_awvalid, m_axi_wvalid}, 0);
    do_read(32'h0, 32'h0, 64'h77, 2'b00);
    chk("mis_followup_read", resp_data_o, 32'h77);
    resp_yumi_i = 1'b1;
    step();
    resp_yumi_i = 1'b0;

    // 1B write with error response
    do_reset();
    send_word(32'h1); send_word(32'h3); send_word(32'h5A);
    chk("err_wdata", m_axi_wdata, 64'h5A5A5A5A_5A5A5A5A);
    chk("err_wstrb", m_axi_wstrb, 8'h08);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    chk("err_no_error_yet", error_o, 0);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    step();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    chk("err_bresp", error_o, 1);

    // Reset while waiting in the read-data phase
    do_reset();
    do_read(32'h0, 32'h0, 64'h11, 2'b00);
    chk("mid_count1", resp_count_o, 1);
    send_word(32'h0); send_word(32'h0);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    chk("mid_in_r", m_axi_rready, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_cmd_ready", cmd_ready_and_o, 0);
    chk("mid_rst_count", resp_count_o, 0);
    chk("mid_rst_resp_v", resp_v_o, 0);
    chk("mid_rst_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    reset = 1'b0;
    step();
    chk("mid_post_idle", cmd_ready_and_o, 1);
    chk("mid_post_rready", m_axi_rready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
